// File: rtl/fourphase_rx_bridge_pkg.sv
// Shared definitions for the asynchronous-interface receive bridge.
package fourphase_rx_bridge_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_DATA_W      = 32;

    typedef logic [DEFAULT_DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        ACK_HI = 2'd2
    } rx_state_t;

endpackage

// File: rtl/fourphase_rx_bridge_bit_sync.sv
// Multi-flop synchroniser for one asynchronous single-bit crossing.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; only the last flop is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fourphase_rx_bridge.sv
// Receive end of a four-phase bundled-data channel: synchronises req, captures
// the bundled word into a one-entry buffer and returns a flop-driven ack.
//
// state  | meaning
// RESYNC | after reset: flush synchroniser, then wait for req to be low
// IDLE   | ack low, waiting for req with a free buffer
// ACK_HI | word captured, ack high, waiting for req to return to zero
module fourphase_rx_bridge
    import fourphase_rx_bridge_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i
);

    logic      req_s;
    logic      pop;
    logic      buf_free;
    rx_state_t state;
    // The synchroniser also resets to 0, so a req held high across reset would
    // read as low for SYNC_STAGES edges. RESYNC ignores req_s until it is valid.
    logic [2:0] flush_cnt;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk(clk),
        .rst(rst),
        .d  (req_i),
        .q  (req_s)
    );

    assign pop      = valid_o && ready_i;
    assign buf_free = !valid_o || pop;

    // Handshake FSM with registered ack, buffer valid and buffer data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESYNC;
            flush_cnt <= 3'(SYNC_STAGES);
            ack_o     <= 1'b0;
            valid_o   <= 1'b0;
            data_o    <= '0;
        end else begin
            if (pop) begin
                valid_o <= 1'b0;
            end
            case (state)
                RESYNC: begin
                    ack_o <= 1'b0;
                    if (flush_cnt != 3'd0) begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end else if (!req_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (req_s && buf_free) begin
                        data_o  <= data_i;
                        valid_o <= 1'b1;
                        ack_o   <= 1'b1;
                        state   <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!req_s) begin
                        ack_o <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ack_o <= 1'b0;
                    state <= RESYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fourphase_rx_bridge.sv
// Directed self-checking bench for fourphase_rx_bridge (DATA_W=32, SYNC_STAGES=2).
module tb_fourphase_rx_bridge;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic [31:0] data_i;
    logic        ack_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;

    logic        req_man;
    logic [31:0] data_man;
    logic        ring_en;
    logic        c_out;
    logic        src_a;
    logic [31:0] ring_data;
    int          ring_acks;

    int          n_tests;
    int          n_fail;
    int          ack_glitches;
    time         last_edge;
    logic [31:0] mon_q[$];

    fourphase_rx_bridge #(
        .DATA_W     (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .data_i (data_i),
        .ack_o  (ack_o),
        .valid_o(valid_o),
        .data_o (data_o),
        .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign req_i  = ring_en ? c_out : req_man;
    assign data_i = ring_en ? ring_data : data_man;

    // Upstream model: eager source (inverter on ack) feeding a C-element whose
    // b input is ack_o through an inverting bubble; the C-element drives req_i.
    assign #2 src_a = ~ack_o;
    initial c_out = 1'b0;
    always @(src_a or ack_o) begin
        if (src_a && !ack_o)
            c_out <= #1 1'b1;
        else if (!src_a && ack_o)
            c_out <= #1 1'b0;
    end

    // Source advances its word after each return-to-zero of ack.
    always @(negedge ack_o) begin
        if (ring_en) ring_data <= ring_data + 32'd1;
    end

    always @(posedge ack_o) begin
        if (ring_en) ring_acks <= ring_acks + 1;
    end

    // Consumer side monitor: a pop happens at the next edge when valid&&ready.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) mon_q.push_back(data_o);
    end

    // ack_o may only move on a clk edge, or asynchronously from reset.
    always @(posedge clk) last_edge = $time;
    always @(ack_o) begin
        if (!rst && $time != last_edge) ack_glitches++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ack(input logic val, input int max_cyc, output int n);
        n = 0;
        while (ack_o !== val && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    int n1;
    int n2;
    logic saw_ack;

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        ack_glitches = 0;
        ring_en      = 1'b0;
        ring_data    = 32'd0;
        ring_acks    = 0;
        req_man      = 1'b0;
        data_man     = 32'd0;
        ready_i      = 1'b0;
        rst          = 1'b1;

        // Reset values
        step_n(3);
        check_eq("rst_ack", ack_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_data", data_o, 0);
        rst = 1'b0;
        step_n(5);

        // 1: single word, latency 3 edges each way
        data_man = 32'hDEADBEEF;
        req_man  = 1'b1;
        ready_i  = 1'b1;
        step_n(2);
        check_eq("t1_ack_early", ack_o, 0);
        step();
        check_eq("t1_ack_rise", ack_o, 1);
        check_eq("t1_valid", valid_o, 1);
        check_eq("t1_data", data_o, 32'hDEADBEEF);
        step();
        check_eq("t1_popped", valid_o, 0);
        req_man = 1'b0;
        step_n(2);
        check_eq("t1_ack_hold", ack_o, 1);
        step();
        check_eq("t1_ack_fall", ack_o, 0);

        // 2: backpressure
        ready_i  = 1'b0;
        data_man = 32'h1;
        req_man  = 1'b1;
        wait_ack(1'b1, 10, n1);
        check_eq("t2_w1_lat", n1, 3);
        req_man = 1'b0;
        wait_ack(1'b0, 10, n2);
        check_eq("t2_w1_rtz", n2, 3);
        data_man = 32'h2;
        req_man  = 1'b1;
        saw_ack  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_o) saw_ack = 1'b1;
        end
        check_eq("t2_stall_ack", saw_ack, 0);
        check_eq("t2_hold_data", data_o, 32'h1);
        check_eq("t2_hold_valid", valid_o, 1);
        mon_q.delete();
        ready_i = 1'b1;
        step();
        check_eq("t2_swap_ack", ack_o, 1);
        check_eq("t2_swap_valid", valid_o, 1);
        check_eq("t2_swap_data", data_o, 32'h2);
        step();
        check_eq("t2_w2_popped", valid_o, 0);
        check_eq("t2_pop_count", mon_q.size(), 2);
        if (mon_q.size() == 2) begin
            check_eq("t2_pop0", mon_q[0], 32'h1);
            check_eq("t2_pop1", mon_q[1], 32'h2);
        end
        req_man = 1'b0;
        wait_ack(1'b0, 10, n2);

        // 3: back-to-back stream of 8 words, 6 clocks per handshake
        mon_q.delete();
        for (int w = 0; w < 8; w++) begin
            data_man = 32'(w);
            req_man  = 1'b1;
            wait_ack(1'b1, 10, n1);
            req_man = 1'b0;
            wait_ack(1'b0, 10, n2);
            check_eq($sformatf("t3_cyc%0d", w), n1 + n2, 6);
        end
        step();
        check_eq("t3_count", mon_q.size(), 8);
        for (int w = 0; w < 8 && w < mon_q.size(); w++)
            check_eq($sformatf("t3_word%0d", w), mon_q[w], 32'(w));

        // 4: req held high across reset must not be taken as a transfer
        mon_q.delete();
        data_man = 32'h12345678;
        req_man  = 1'b1;
        rst      = 1'b1;
        step_n(2);
        rst = 1'b0;
        step_n(10);
        check_eq("t4_ack", ack_o, 0);
        check_eq("t4_valid", valid_o, 0);
        check_eq("t4_nocap", mon_q.size(), 0);
        req_man = 1'b0;
        step_n(4);
        data_man = 32'hA5A5A5A5;
        req_man  = 1'b1;
        wait_ack(1'b1, 10, n1);
        check_eq("t4_lat", n1, 3);
        req_man = 1'b0;
        wait_ack(1'b0, 10, n2);
        step();
        check_eq("t4_count", mon_q.size(), 1);
        if (mon_q.size() >= 1) check_eq("t4_word", mon_q[0], 32'hA5A5A5A5);

        // 5: reset in ACK_HI clears ack and valid before the next edge
        ready_i  = 1'b0;
        data_man = 32'h55;
        req_man  = 1'b1;
        wait_ack(1'b1, 10, n1);
        check_eq("t5_pre_valid", valid_o, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t5_async_ack", ack_o, 0);
        check_eq("t5_async_valid", valid_o, 0);
        check_eq("t5_async_data", data_o, 0);
        req_man = 1'b0;
        step_n(2);
        rst = 1'b0;
        step_n(6);

        // 6: closed loop with the C-element upstream, 100 transfers
        mon_q.delete();
        ready_i   = 1'b1;
        ring_data = 32'd0;
        ring_acks = 0;
        ring_en   = 1'b1;
        n1 = 0;
        while (ring_acks < 100 && n1 < 1200) begin
            step();
            n1++;
        end
        check_eq("t6_no_deadlock", ring_acks >= 100, 1);
        @(negedge ack_o or posedge clk);
        ring_en = 1'b0;
        wait_ack(1'b0, 10, n2);
        step_n(2);
        check_eq("t6_count_min", mon_q.size() >= 100, 1);
        n2 = 0;
        for (int w = 0; w < mon_q.size(); w++)
            if (mon_q[w] !== 32'(w)) n2++;
        check_eq("t6_order", n2, 0);
        check_eq("t6_ack_glitch", ack_glitches, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fourphase_rx_bridge.md
Name: fourphase_rx_bridge

Overview:
- Receiving end of a self-timed, four-phase bundled-data channel, placed directly downstream of the c_element_m-based handshake pipeline.
- Synchronises the incoming request and captures the bundled data into a one-entry buffer.
- Returns a glitch-free acknowledge and presents the word on a synchronous valid/ready interface to the clocked core.

Parameters:
DATA_W, 32, width of bundled data word
SYNC_STAGES, 2, flops in req synchroniser (legal range 2..4)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
req_i  input  1  four-phase request from upstream C-element stage (asynchronous to clk)
data_i  input  DATA_W  bundled data; stable from before req_i rises until after ack_o rises
ack_o  output  1  four-phase acknowledge to upstream C-element stage
valid_o  output  1  buffered word available
data_o  output  DATA_W  buffered word
ready_i  input  1  core consumes word when valid_o && ready_i at clk edge

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). All flops clear immediately on rst assertion.
- Reset values: ack_o=0, valid_o=0, data_o=0, synchroniser flops=0, FSM=RESYNC.
- ack_o comes straight from a flop, with no combinational logic on the output. It must never glitch because it feeds a C-element.
- req_s is req_i after SYNC_STAGES flops. No other logic may sample req_i.
- Buffer: one entry, holding valid_o and data_o.
  - Pop on valid_o && ready_i.
  - The buffer counts as free when valid_o==0, or when a pop happens in the same cycle.
- FSM states:
  - RESYNC: ack_o=0. Waits for req_s==0, then goes to IDLE. This stops a request left high across a reset being taken as a new transfer.
  - IDLE: ack_o=0.
    - If req_s==1 and the buffer is free: capture data_i into data_o, set valid_o=1, set ack_o=1 on the same edge, go to ACK_HI.
    - If req_s==1 and the buffer is full: stay in IDLE with ack_o=0. This stalls upstream.
  - ACK_HI: ack_o=1. On req_s==0: ack_o=0, go to IDLE.
- Latency and throughput:
  - req_i rise to valid_o=1 and ack_o=1: SYNC_STAGES+1 clk edges if the buffer is free.
  - req_i fall to ack_o=0: SYNC_STAGES+1 edges.
  - Minimum cycle per transfer: 2*(SYNC_STAGES+1) clocks.
- Decoupling: once data is captured, ack is raised without waiting for the core. The core may hold ready_i low indefinitely. The next transfer then stalls in IDLE.
- Simultaneous events:
  - Pop and capture in the same cycle: allowed. valid_o stays 1 and data_o takes the new word.
  - Pop alone: valid_o goes to 0.
- data_o holds its value while valid_o==1 && ready_i==0.
- Reset mid-transfer: ack_o drops at once and any buffered word is discarded. After rst deasserts the FSM is in RESYNC, so upstream must complete its return-to-zero before the next word is accepted.
- No protocol error detection. A req_i pulse shorter than SYNC_STAGES clocks is undefined; upstream guarantees the four-phase ordering.

Decomposition:
- Shared async-interface package holds:
  - the FSM state enum (RESYNC, IDLE, ACK_HI)
  - a DEFAULT_SYNC_STAGES=2 constant
  - the bundled-data word typedef, default 32 bits
- One sub-module: bit_sync.
  - Parameterised SYNC_STAGES flop chain.
  - Same async active-high rst, reset value 0.
  - Reused for every asynchronous single-bit crossing.

Test Plan:
1. Single word: rst pulse, then data_i=32'hDEADBEEF, req_i=1, ready_i=1 → valid_o=1 and ack_o=1 exactly 3 clocks after req_i (SYNC_STAGES=2); data_o=32'hDEADBEEF; valid_o=0 the next cycle. Then req_i=0 → ack_o=0 3 clocks later.
2. Backpressure: ready_i=0. Send 32'h1, which is acked. Send 32'h2 → ack_o stays 0 and data_o stays 32'h1 for 20 clocks. Raise ready_i → pop 32'h1 the same cycle 32'h2 is captured, ack_o rises, valid_o stays 1.
3. Back-to-back stream: 8 words 0..7 with ready_i=1 → all 8 delivered in order with no duplicates or drops. Each four-phase cycle takes 6 clocks.
4. Reset with req high: req_i=1 held through a rst pulse → after reset ack_o=0 and valid_o=0, no capture. Drop req_i then re-raise with 32'hA5A5A5A5 → single capture of 32'hA5A5A5A5.
5. Reset mid-transfer: assert rst while in ACK_HI with valid_o=1 → ack_o and valid_o go 0 asynchronously, before the next clk edge.
6. Bench integration: fourphase_rx_bridge ack_o wired to c_element_m input b, with the C-element output driving req_i → handshake oscillates with no deadlock for 100 transfers, and ack_o never glitches (checked by an assertion that ack_o changes only at clk edges).
